// File: rtl/gcd_pkg.sv
// Shared FSM state encoding for the Euclid GCD engine.
package gcd_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_TEST = 3'd1;
    localparam logic [STATE_W-1:0] ST_SWAP = 3'd2;
    localparam logic [STATE_W-1:0] ST_SUB  = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparison flags, subtract/swap path and result register for gcd_unit.
module gcd_datapath
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             swap_i,
    input  logic             sub_i,
    input  logic             latch_i,
    input  logic [WIDTH-1:0] a_in_i,
    input  logic [WIDTH-1:0] b_in_i,
    output logic             a_zero_o,
    output logic             b_zero_o,
    output logic             eq_o,
    output logic             lt_o,
    output logic [WIDTH-1:0] result_o
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;

    assign a_zero_o = (a_q == {WIDTH{1'b0}});
    assign b_zero_o = (b_q == {WIDTH{1'b0}});
    assign eq_o     = (a_q == b_q);
    assign lt_o     = (a_q < b_q);
    assign result_o = result_q;

    // Next operand values: load, swap or subtract; the FSM only subtracts when a >= b.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (load_i) begin
            a_d = a_in_i;
            b_d = b_in_i;
        end else if (swap_i) begin
            a_d = b_q;
            b_d = a_q;
        end else if (sub_i) begin
            a_d = a_q - b_q;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
    end

    // Result capture on termination; gcd(0,x) is x.
    always_comb begin
        if (latch_i) begin
            result_d = a_zero_o ? b_q : a_q;
        end else begin
            result_d = result_q;
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Euclid GCD engine (subtract/swap) with start/busy/done handshake.
// Optional step counter port 'steps' enabled by defining GCD_STEP_COUNT_EN.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef GCD_STEP_COUNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [CNT_W-1:0] steps
`endif
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load_s, swap_s, sub_s, latch_s;
    logic               a_zero_s, b_zero_s, eq_s, lt_s;

    gcd_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (load_s),
        .swap_i  (swap_s),
        .sub_i   (sub_s),
        .latch_i (latch_s),
        .a_in_i  (a_in),
        .b_in_i  (b_in),
        .a_zero_o(a_zero_s),
        .b_zero_o(b_zero_s),
        .eq_o    (eq_s),
        .lt_o    (lt_s),
        .result_o(result)
    );

    // FSM next state and datapath enables.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        swap_s  = 1'b0;
        sub_s   = 1'b0;
        latch_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_d = ST_TEST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TEST: begin
                if (a_zero_s || b_zero_s || eq_s) begin
                    latch_s = 1'b1;
                    state_d = ST_DONE;
                end else if (lt_s) begin
                    state_d = ST_SWAP;
                end else begin
                    state_d = ST_SUB;
                end
            end
            ST_SWAP: begin
                swap_s  = 1'b1;
                state_d = ST_SUB;
            end
            ST_SUB: begin
                sub_s   = 1'b1;
                state_d = ST_TEST;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered alongside the state they decode.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // FSM and handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

`ifdef GCD_STEP_COUNT_EN
    logic [CNT_W-1:0] steps_q, steps_d;

    // Step counter: cleared on accepted start, saturating count of compute cycles.
    always_comb begin
        if (load_s) begin
            steps_d = {CNT_W{1'b0}};
        end else if (((state_q == ST_TEST) || (state_q == ST_SWAP) || (state_q == ST_SUB))
                     && (steps_q != {CNT_W{1'b1}})) begin
            steps_d = steps_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            steps_d = steps_q;
        end
    end

    // Step counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps_q <= {CNT_W{1'b0}};
        end else begin
            steps_q <= steps_d;
        end
    end

    assign steps = steps_q;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit at WIDTH=8 and WIDTH=16 against an arithmetic GCD model.
module tb_gcd_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8;
    logic [7:0]  res8;
    logic        start16 = 1'b0;
    logic [15:0] a16 = 16'd0, b16 = 16'd0;
    logic        busy16, done16;
    logic [15:0] res16;
`ifdef GCD_STEP_COUNT_EN
    logic [15:0] steps8, steps16;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gcd_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(res8)
`ifdef GCD_STEP_COUNT_EN
        , .steps(steps8)
`endif
    );

    gcd_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16),
        .busy(busy16), .done(done16), .result(res16)
`ifdef GCD_STEP_COUNT_EN
        , .steps(steps16)
`endif
    );

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Compute cycles: one TEST per iteration, plus SWAP when a<b, plus SUB.
    function automatic int ref_steps(input int a, input int b);
        int n = 0;
        int t;
        forever begin
            n++;
            if (a == 0 || b == 0 || a == b) return n;
            if (a < b) begin
                t = a; a = b; b = t;
                n++;
            end
            a = a - b;
            n++;
        end
    endfunction

    task automatic wait_idle8();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int done_cyc, output bit busy_ok);
        wait_idle8();
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        done_cyc = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 1200; c++) begin
            if (done8) begin
                done_cyc = c;
                break;
            end
            if (!busy8) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
        res = res8;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] res, output int done_cyc);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy16) break;
        end
        start16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk); #1;
        start16 = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 1200; c++) begin
            if (done16) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        res = res16;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy8, done8, res8} !== 10'd0) $display("FAIL reset8 got busy=%b done=%b result=%0d want 0/0/0", busy8, done8, res8);
        else n_pass++;
        n_checks++;
        if ({busy16, done16, res16} !== 18'd0) $display("FAIL reset16 got busy=%b done=%b result=%0d want 0/0/0", busy16, done16, res16);
        else n_pass++;
`ifdef GCD_STEP_COUNT_EN
        n_checks++;
        if (steps8 !== 16'd0) $display("FAIL reset_steps got %0d want 0", steps8);
        else n_pass++;
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_op8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [7:0] res;
        int cyc;
        bit bok;
        int exp_g, exp_s;
        exp_g = ref_gcd(int'(a), int'(b));
        exp_s = ref_steps(int'(a), int'(b));
        run8(a, b, res, cyc, bok);
        n_checks++;
        if (res !== exp_g[7:0]) $display("FAIL %s_result gcd(%0d,%0d) got %0d want %0d", tag, a, b, res, exp_g);
        else n_pass++;
        n_checks++;
        if (cyc != exp_s + 1) $display("FAIL %s_latency gcd(%0d,%0d) got cycle %0d want %0d", tag, a, b, cyc, exp_s + 1);
        else n_pass++;
        n_checks++;
        if (!bok) $display("FAIL %s_busy gcd(%0d,%0d) got busy low during run want high", tag, a, b);
        else n_pass++;
`ifdef GCD_STEP_COUNT_EN
        n_checks++;
        if (steps8 !== exp_s[15:0]) $display("FAIL %s_steps gcd(%0d,%0d) got %0d want %0d", tag, a, b, steps8, exp_s);
        else n_pass++;
`endif
        @(posedge clk); #1;
        n_checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || res8 !== exp_g[7:0])
            $display("FAIL %s_after_done got done=%b busy=%b result=%0d want 0/0/%0d", tag, done8, busy8, res8, exp_g);
        else n_pass++;
    endtask

    task automatic test_directed();
        check_op8(8'd48, 8'd18, "d48_18");
        check_op8(8'd255, 8'd1, "d255_1");
        check_op8(8'd0, 8'd0, "d0_0");
        check_op8(8'd7, 8'd0, "d7_0");
        check_op8(8'd0, 8'd9, "d0_9");
        check_op8(8'd5, 8'd5, "d5_5");
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 25; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            check_op8(a, b, "rand");
        end
    endtask

    task automatic test_busy_start();
        int cyc;
        wait_idle8();
        start8 = 1'b1; a8 = 8'd48; b8 = 8'd18;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd75;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = -1;
        for (int c = 4; c <= 100; c++) begin
            if (done8) begin
                cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (cyc != 12 || res8 !== 8'd6) $display("FAIL busy_start_ignored got cycle=%0d result=%0d want 12/6", cyc, res8);
        else n_pass++;
        check_op8(8'd100, 8'd75, "after_busy");
    endtask

    task automatic test_reset_midrun();
        bit seen_done = 1'b0;
        bit seen_busy = 1'b0;
        wait_idle8();
        start8 = 1'b1; a8 = 8'd48; b8 = 8'd18;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy8 !== 1'b0 || res8 !== 8'd0 || done8 !== 1'b0)
            $display("FAIL reset_midrun got busy=%b done=%b result=%0d want 0/0/0", busy8, done8, res8);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done8) seen_done = 1'b1;
            if (busy8) seen_busy = 1'b1;
        end
        n_checks++;
        if (seen_done || seen_busy) $display("FAIL reset_no_done got done_seen=%b busy_seen=%b want 0/0", seen_done, seen_busy);
        else n_pass++;
    endtask

    task automatic test_width16();
        logic [15:0] pa [3] = '{16'd65535, 16'd40000, 16'd12345};
        logic [15:0] pb [3] = '{16'd4369, 16'd30000, 16'd0};
        logic [15:0] res;
        int cyc, eg, es;
        for (int i = 0; i < 3; i++) begin
            eg = ref_gcd(int'(pa[i]), int'(pb[i]));
            es = ref_steps(int'(pa[i]), int'(pb[i]));
            run16(pa[i], pb[i], res, cyc);
            n_checks++;
            if (res !== eg[15:0] || cyc != es + 1)
                $display("FAIL w16 gcd(%0d,%0d) got result=%0d cycle=%0d want %0d/%0d", pa[i], pb[i], res, cyc, eg, es + 1);
            else n_pass++;
`ifdef GCD_STEP_COUNT_EN
            n_checks++;
            if (steps16 !== es[15:0]) $display("FAIL w16_steps got %0d want %0d", steps16, es);
            else n_pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_reset_midrun();
        test_width16();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
